// File: rtl/btb_pkg.sv
// Shared constants and helpers for the branch target buffer: 2-bit direction-counter
// states, saturating next-state function and index/tag width helpers.
package btb_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t SN = 2'b00;
   localparam ctr_t WN = 2'b01;
   localparam ctr_t WT = 2'b10;
   localparam ctr_t ST = 2'b11;

   function automatic int unsigned idx_w(input int unsigned entries);
      return $clog2(entries);
   endfunction

   function automatic int unsigned tag_w(input int unsigned xlen, input int unsigned entries);
      return xlen - $clog2(entries) - 2;
   endfunction

   function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
      ctr_t nxt;
      if (taken) begin
         nxt = (ctr == ST) ? ST : ctr + 2'd1;
      end else begin
         nxt = (ctr == SN) ? SN : ctr - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Lookup/update bundle between the pipeline (master) and the branch target buffer (slave).
interface branch_predictor_btb_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
);
   logic [XLEN-1:0]  lookup_pc_i;
   logic             pred_hit_o;
   logic             pred_taken_o;
   logic [XLEN-1:0]  pred_target_o;
   logic             update_valid_i;
   logic [XLEN-1:0]  update_pc_i;
   logic             update_taken_i;
   logic [XLEN-1:0]  update_target_i;
   logic             update_mispredict_i;
   logic [CNT_W-1:0] br_cnt_o;
   logic [CNT_W-1:0] mispred_cnt_o;

   modport master (
      output lookup_pc_i, update_valid_i, update_pc_i, update_taken_i, update_target_i,
             update_mispredict_i,
      input  pred_hit_o, pred_taken_o, pred_target_o, br_cnt_o, mispred_cnt_o
   );

   modport slave (
      input  lookup_pc_i, update_valid_i, update_pc_i, update_taken_i, update_target_i,
             update_mispredict_i,
      output pred_hit_o, pred_taken_o, pred_target_o, br_cnt_o, mispred_cnt_o
   );
endinterface

// File: rtl/sat_counter2.sv
// Combinational next state of a 2-bit saturating branch-direction counter.
module sat_counter2
   import btb_pkg::*;
(
   input  ctr_t ctr_i,
   input  logic taken_i,
   output ctr_t ctr_o
);

   always_comb begin
      ctr_o = ctr_next(ctr_i, taken_i);
   end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit direction counters and branch/mispredict counters.
// Define BTB_GSHARE_EN to index the direction counters with pc XOR global history.
module branch_predictor_btb
   import btb_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned CNT_W   = 32
) (
   input logic                   clk_i,
   input logic                   rst_i,
   branch_predictor_btb_if.slave bus
);

   localparam int unsigned IDX_W = idx_w(ENTRIES);
   localparam int unsigned TAG_W = tag_w(XLEN, ENTRIES);

   typedef logic [IDX_W-1:0] idx_t;
   typedef logic [TAG_W-1:0] tag_t;

   logic            valid_q  [ENTRIES];
   tag_t            tag_q    [ENTRIES];
   logic [XLEN-1:0] target_q [ENTRIES];
   ctr_t            ctr_q    [ENTRIES];

   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

   idx_t            lk_idx, up_idx, lk_ctr_idx, up_ctr_idx;
   tag_t            lk_tag, up_tag;
   logic            lk_hit, lk_ctr_msb;
   ctr_t            up_ctr, up_ctr_next;
   logic [XLEN-1:0] lk_pc_plus4;
   logic            unused_pc_bits;

   assign lk_idx         = bus.lookup_pc_i[IDX_W+1:2];
   assign lk_tag         = bus.lookup_pc_i[XLEN-1:IDX_W+2];
   assign up_idx         = bus.update_pc_i[IDX_W+1:2];
   assign up_tag         = bus.update_pc_i[XLEN-1:IDX_W+2];
   assign lk_pc_plus4    = bus.lookup_pc_i + XLEN'(4);
   assign unused_pc_bits = ^bus.update_pc_i[1:0];

`ifdef BTB_GSHARE_EN
   idx_t ghr_q, ghr_d;

   assign lk_ctr_idx = lk_idx ^ ghr_q;
   assign up_ctr_idx = up_idx ^ ghr_q;
   assign ghr_d      = bus.update_valid_i ? {ghr_q[IDX_W-2:0], bus.update_taken_i} : ghr_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end
`else
   logic up_hit;

   assign lk_ctr_idx = lk_idx;
   assign up_ctr_idx = up_idx;
   assign up_hit     = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
`endif

   assign lk_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lk_ctr_msb = ctr_q[lk_ctr_idx][1];
   assign up_ctr     = ctr_q[up_ctr_idx];

   sat_counter2 u_sat_counter2 (
      .ctr_i   (up_ctr),
      .taken_i (bus.update_taken_i),
      .ctr_o   (up_ctr_next)
   );

   // Lookup reads the pre-update arrays: no same-cycle bypass from the update port.
   always_comb begin
      bus.pred_hit_o    = 1'b0;
      bus.pred_taken_o  = 1'b0;
      bus.pred_target_o = lk_pc_plus4;
      if (rst_i) begin
         bus.pred_hit_o   = lk_hit;
         bus.pred_taken_o = lk_hit & lk_ctr_msb;
         if (lk_hit && lk_ctr_msb) begin
            bus.pred_target_o = target_q[lk_idx];
         end
      end
   end

   // Tag and target are left unreset; valid gates their use.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[idx_t'(i)] <= 1'b0;
            ctr_q[idx_t'(i)]   <= WN;
         end
      end else if (bus.update_valid_i) begin
         if (bus.update_taken_i) begin
            valid_q[up_idx]  <= 1'b1;
            tag_q[up_idx]    <= up_tag;
            target_q[up_idx] <= bus.update_target_i;
         end
`ifdef BTB_GSHARE_EN
         ctr_q[up_ctr_idx] <= up_ctr_next;
`else
         if (up_hit) begin
            ctr_q[up_idx] <= up_ctr_next;
         end else if (bus.update_taken_i) begin
            ctr_q[up_idx] <= WT;
         end
`endif
      end
   end

   always_comb begin
      br_cnt_d      = br_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (bus.update_valid_i) begin
         br_cnt_d = br_cnt_q + CNT_W'(1);
         if (bus.update_mispredict_i) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         br_cnt_q      <= '0;
         mispred_cnt_q <= '0;
      end else begin
         br_cnt_q      <= br_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end

   assign bus.br_cnt_o      = br_cnt_q;
   assign bus.mispred_cnt_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: abstract BTB model checked every cycle plus
// hand-computed literal expectations.
module tb_branch_predictor_btb;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned ENTRIES = 64;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned IDX_W   = 6;

   logic clk = 1'b0;
   logic rst_i;
   always #5 clk = ~clk;

   branch_predictor_btb_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

   branch_predictor_btb #(
      .XLEN    (XLEN),
      .ENTRIES (ENTRIES),
      .CNT_W   (CNT_W)
   ) dut (
      .clk_i (clk),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int n_pass  = 0;
   int n_total = 0;
   bit check_en = 1'b0;

   // Model: per-slot valid/tag/target, direction counters as integers 0..3.
   bit          m_valid  [ENTRIES];
   logic [31:0] m_tag    [ENTRIES];
   logic [31:0] m_target [ENTRIES];
   int          m_ctr    [ENTRIES];
   int          m_ghr;
   int          m_br;
   int          m_mis;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic int slot(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc);
      return pc >> (IDX_W + 2);
   endfunction

   function automatic int dir_slot(input logic [31:0] pc);
`ifdef BTB_GSHARE_EN
      return slot(pc) ^ m_ghr;
`else
      return slot(pc);
`endif
   endfunction

   function automatic bit m_hit(input logic [31:0] pc);
      return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
   endfunction

   function automatic int sat(input int c, input bit taken);
      if (taken) return (c + 1 > 3) ? 3 : c + 1;
      return (c - 1 < 0) ? 0 : c - 1;
   endfunction

   function automatic bit exp_hit(input logic [31:0] pc);
      return (rst_i === 1'b1) && m_hit(pc);
   endfunction

   function automatic bit exp_taken(input logic [31:0] pc);
      return exp_hit(pc) && (m_ctr[dir_slot(pc)] >= 2);
   endfunction

   function automatic logic [31:0] exp_target(input logic [31:0] pc);
      return exp_taken(pc) ? m_target[slot(pc)] : pc + 32'd4;
   endfunction

   always @(posedge clk) begin
      if (!rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] <= 1'b0;
            m_ctr[i]   <= 1;
         end
         m_ghr <= 0;
         m_br  <= 0;
         m_mis <= 0;
      end else if (bus.update_valid_i) begin
`ifdef BTB_GSHARE_EN
         m_ctr[dir_slot(bus.update_pc_i)] <= sat(m_ctr[dir_slot(bus.update_pc_i)],
                                                 bus.update_taken_i);
         m_ghr <= (m_ghr * 2 + int'(bus.update_taken_i)) % ENTRIES;
`else
         if (m_hit(bus.update_pc_i))
            m_ctr[slot(bus.update_pc_i)] <= sat(m_ctr[slot(bus.update_pc_i)],
                                                bus.update_taken_i);
         else if (bus.update_taken_i)
            m_ctr[slot(bus.update_pc_i)] <= 2;
`endif
         if (bus.update_taken_i) begin
            m_valid[slot(bus.update_pc_i)]  <= 1'b1;
            m_tag[slot(bus.update_pc_i)]    <= tag_of(bus.update_pc_i);
            m_target[slot(bus.update_pc_i)] <= bus.update_target_i;
         end
         m_br  <= (m_br + 1) % (1 << CNT_W);
         m_mis <= (m_mis + int'(bus.update_mispredict_i)) % (1 << CNT_W);
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         chk("model_hit", 32'(bus.pred_hit_o), 32'(exp_hit(bus.lookup_pc_i)));
         chk("model_taken", 32'(bus.pred_taken_o), 32'(exp_taken(bus.lookup_pc_i)));
         chk("model_target", bus.pred_target_o, exp_target(bus.lookup_pc_i));
         chk("model_br_cnt", 32'(bus.br_cnt_o), 32'(m_br));
         chk("model_mispred_cnt", 32'(bus.mispred_cnt_o), 32'(m_mis));
      end
   end

   // Drive one cycle of inputs just after the rising edge; return at the falling edge.
   task automatic step(input logic rst, input logic [31:0] lpc, input logic uv,
                       input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic umis);
      @(posedge clk);
      #1;
      rst_i                   = rst;
      bus.lookup_pc_i         = lpc;
      bus.update_valid_i      = uv;
      bus.update_pc_i         = upc;
      bus.update_taken_i      = ut;
      bus.update_target_i     = utgt;
      bus.update_mispredict_i = umis;
      @(negedge clk);
   endtask

   task automatic idle(input logic [31:0] lpc);
      step(1'b1, lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic lit(input string name, input logic hit, input logic taken,
                      input logic [31:0] tgt);
      chk({name, "_hit"}, 32'(bus.pred_hit_o), 32'(hit));
      chk({name, "_taken"}, 32'(bus.pred_taken_o), 32'(taken));
      chk({name, "_target"}, bus.pred_target_o, tgt);
   endtask

   initial begin
      rst_i                   = 1'b0;
      bus.lookup_pc_i         = 32'h100;
      bus.update_valid_i      = 1'b0;
      bus.update_pc_i         = 32'h0;
      bus.update_taken_i      = 1'b0;
      bus.update_target_i     = 32'h0;
      bus.update_mispredict_i = 1'b0;
      @(posedge clk);
      check_en = 1'b1;

      step(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      lit("in_reset", 1'b0, 1'b0, 32'h104);
      step(1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1);
      idle(32'h100);
      lit("after_reset", 1'b0, 1'b0, 32'h104);
      chk("after_reset_br", 32'(bus.br_cnt_o), 32'd0);

      step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h40, 1'b1);
      chk("same_cycle_hit", 32'(bus.pred_hit_o), 32'd0);
      idle(32'h100);
      lit("alloc", 1'b1, 1'b1, 32'h40);
      chk("alloc_br", 32'(bus.br_cnt_o), 32'd1);

      step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
`ifndef BTB_GSHARE_EN
      lit("pre_nt1", 1'b1, 1'b1, 32'h40);
`endif
      step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
`ifndef BTB_GSHARE_EN
      lit("wn", 1'b1, 1'b0, 32'h104);
`endif
      idle(32'h100);
`ifndef BTB_GSHARE_EN
      lit("sn", 1'b1, 1'b0, 32'h104);
`endif
      chk("three_br", 32'(bus.br_cnt_o), 32'd3);
      chk("three_mis", 32'(bus.mispred_cnt_o), 32'd2);

      step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
      idle(32'h100);
`ifndef BTB_GSHARE_EN
      lit("sn_sat_then_wn", 1'b1, 1'b0, 32'h104);
`endif
      for (int i = 0; i < 3; i++) step(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b0);
      idle(32'h100);
`ifndef BTB_GSHARE_EN
      lit("st", 1'b1, 1'b1, 32'h80);
`endif
      step(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
      idle(32'h100);
`ifndef BTB_GSHARE_EN
      lit("st_sat_then_wt", 1'b1, 1'b1, 32'h80);
`endif

      step(1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0);
      idle(32'h100);
      lit("alias_old", 1'b0, 1'b0, 32'h104);
      idle(32'h200);
`ifndef BTB_GSHARE_EN
      lit("alias_new", 1'b1, 1'b1, 32'h300);
`endif
      step(1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0);
      idle(32'h400);
      chk("miss_nt_no_alloc", 32'(bus.pred_hit_o), 32'd0);
      idle(32'h200);
      chk("miss_nt_keeps", 32'(bus.pred_hit_o), 32'd1);

      idle(32'hFFFF_FFFC);
      chk("pc_wrap_target", bus.pred_target_o, 32'h0);

      for (int i = 0; i < 24; i++) begin
         step(1'b1, 32'h1000 + 32'((i % 5) * 4), 1'b1, 32'h1000 + 32'((i % 4) * 4),
              1'(((i * 7) % 3) != 0), 32'h2000 + 32'(i * 16), 1'(i % 2));
      end

      step(1'b0, 32'h200, 1'b1, 32'h104, 1'b1, 32'h500, 1'b1);
      idle(32'h104);
      chk("rst_discard_hit", 32'(bus.pred_hit_o), 32'd0);
      chk("rst_discard_br", 32'(bus.br_cnt_o), 32'd0);
      chk("rst_discard_mis", 32'(bus.mispred_cnt_o), 32'd0);
      idle(32'h200);
      chk("rst_clears_valid", 32'(bus.pred_hit_o), 32'd0);

      for (int i = 0; i < 255; i++) begin
         step(1'b1, 32'h3000, 1'b1, 32'h3000 + 32'((i % 8) * 4), 1'b0, 32'h0, 1'b1);
      end
      idle(32'h3000);
      chk("cnt_max_br", 32'(bus.br_cnt_o), 32'hFF);
      chk("cnt_max_mis", 32'(bus.mispred_cnt_o), 32'hFF);
      step(1'b1, 32'h3000, 1'b1, 32'h3000, 1'b0, 32'h0, 1'b1);
      idle(32'h3000);
      chk("cnt_wrap_br", 32'(bus.br_cnt_o), 32'h0);
      chk("cnt_wrap_mis", 32'(bus.mispred_cnt_o), 32'h0);

`ifdef BTB_GSHARE_EN
      step(1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 24; i++) begin
         step(1'b1, 32'h100, 1'b1, 32'h100, 1'((i % 2) == 0), 32'h40, 1'b0);
         if (i >= 12) chk("gshare_alt", 32'(bus.pred_taken_o), 32'((i % 2) == 0));
      end
`endif

      idle(32'h0);
      check_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
Direct-mapped branch target buffer with 2-bit saturating direction counters for the pipelined MIPS core. The IF stage looks up the current PC combinationally and gets a predicted next PC. The branch-resolve stage writes back actual outcomes, so the core redirects on mispredict instead of always flushing on taken branches. The block also keeps branch and mispredict performance counters.

Parameters:
XLEN, 32, PC/target width
ENTRIES, 64, BTB entries; power of 2, >= 4
CNT_W, 32, width of perf counters
(derived, not overridable) IDX_W = log2(ENTRIES); TAG_W = XLEN-IDX_W-2

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, synchronous, active-low
lookup_pc_i  in  XLEN  PC of instruction in IF
pred_hit_o  out  1  valid tag match for lookup_pc_i
pred_taken_o  out  1  predicted taken
pred_target_o  out  XLEN  predicted next PC
update_valid_i  in  1  a resolved branch is presented this cycle
update_pc_i  in  XLEN  PC of resolved branch
update_taken_i  in  1  actual direction
update_target_i  in  XLEN  actual taken target
update_mispredict_i  in  1  pipeline flagged redirect for this branch
br_cnt_o  out  CNT_W  resolved branches since reset
mispred_cnt_o  out  CNT_W  mispredicts since reset

Behaviour:
- Index is pc[IDX_W+1:2]; tag is pc[XLEN-1:IDX_W+2]. pc[1:0] is ignored.
- Each entry holds valid, tag, target[XLEN], and ctr[2]. Counter states: SN=00, WN=01, WT=10, ST=11.
- Lookup is purely combinational (0-cycle latency).
  - hit = valid & tag match.
  - pred_taken_o = hit & ctr[1].
  - pred_target_o = target when pred_taken_o, else lookup_pc_i+4. The +4 wraps modulo 2^XLEN.
- Update is registered at the rising edge when update_valid_i=1:
  - Hit, taken: ctr saturating +1 (ST stays ST); target <= update_target_i.
  - Hit, not taken: ctr saturating -1 (SN stays SN); target unchanged.
  - Miss, taken: allocate and overwrite any aliased entry: valid=1, tag, target, ctr=WT.
  - Miss, not taken: no change to the entry.
  - br_cnt_o +1. mispred_cnt_o +1 if update_mispredict_i. Both counters wrap modulo 2^CNT_W.
- Simultaneous lookup and update of the same index: the lookup sees the pre-update entry. There is no bypass; the new value is visible the next cycle.
- update_mispredict_i without update_valid_i is ignored.
- Reset (rst_i=0 at a clock edge) takes priority over update:
  - All valid <= 0, all ctr <= WN, and both counters <= 0. Tag and target are not reset.
  - While rst_i=0, outputs are forced: pred_hit_o=0, pred_taken_o=0, pred_target_o=lookup_pc_i+4.
  - Reset mid-operation discards any update presented in the same cycle.
- After reset, every lookup misses until an allocation occurs.

Optional Feature:
Macro BTB_GSHARE_EN.
- Defined:
  - Adds an IDX_W-bit global history register (GHR), reset to 0.
  - The direction-counter index becomes pc[IDX_W+1:2] XOR GHR for both lookup and update.
  - The tag/target array index stays pc-only.
  - Counters live in a separate ENTRIES-deep array, reset to WN and updated on every update_valid_i (hit or miss). The allocate rule is otherwise unchanged.
  - GHR <= {GHR[IDX_W-2:0], update_taken_i} on each update; it is non-speculative.
  - pred_taken_o = hit & pht_ctr[1].
- Not defined: no GHR; the counter is stored per BTB entry as described above.

Decomposition:
- Package btb_pkg: counter-state constants SN/WN/WT/ST; function ctr_next(ctr, taken) implementing saturation; localparam helpers for IDX_W/TAG_W.
- One sub-module, sat_counter2, holds the combinational 2-bit saturating next-state. It is instantiated for the update path.
- Arrays and perf counters stay in the top module.

Test Plan:
1. Reset, then lookup_pc_i=0x100 -> pred_hit_o=0, pred_taken_o=0, pred_target_o=0x104; br_cnt_o=0.
2. Update pc=0x100, taken=1, target=0x040 -> next cycle lookup 0x100 gives hit=1, taken=1 (ctr=WT), target=0x040; br_cnt_o=1.
3. Same branch resolved not-taken twice -> ctr WT->WN->SN; lookup gives hit=1, taken=0, target=0x104. A third not-taken keeps SN. Four taken updates -> ST and stays ST.
4. Alias (ENTRIES=64): allocate 0x100 taken, then update 0x200 taken target 0x300 -> lookup 0x100 misses (target 0x104); lookup 0x200 hits with target 0x300.
5. Same-cycle lookup and update of index 0x100 (entry invalid) -> that cycle hit=0; next cycle hit=1. Assert rst_i=0 with update_valid_i=1 -> entry not written, counters 0.
6. Three updates with update_mispredict_i=1,0,1 -> mispred_cnt_o=2, br_cnt_o=3. Preload counters to all-ones and update once -> both wrap to 0. With BTB_GSHARE_EN, alternating T/N at one PC -> distinct PHT entries trained; prediction accuracy 100% after warm-up.
